// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pkg
// Description : Shared constants and types for the GPIO input debounce block.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

  // Number of raw board input channels on the parallel port.
  localparam int GPIO_WIDTH = 20;

  // 10 us sample period at a 50 MHz system clock.
  localparam int DEF_TICK_DIV = 500;

  // 100 sample ticks (1 ms) of a stable new level before it is accepted.
  localparam int DEF_STABLE_TICKS = 100;

  // What a channel does on the current clock edge.
  typedef enum logic [1:0] {
    CH_MATCH  = 2'd0,  // input equals clean level: restart the accept timer
    CH_WAIT   = 2'd1,  // mismatch but no sample tick: hold the count
    CH_COUNT  = 2'd2,  // mismatch on a sample tick: advance the count
    CH_ACCEPT = 2'd3   // mismatch held long enough: take the new level
  } ch_action_e;

endpackage : gpio_pkg
`default_nettype wire

// File: rtl/debounce_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : debounce_tick_gen
// Description : Sample-tick prescaler. Produces a one-cycle tick every
//               TICK_DIV clock cycles; TICK_DIV = 1 ticks on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_tick_gen
  import gpio_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  // A one-bit counter is kept even for TICK_DIV = 1 so there is a single
  // code path; it then sits at zero and tick stays high.
  localparam int              CNT_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] c_TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

  logic [CNT_W-1:0] tick_cnt_q;
  logic [CNT_W-1:0] tick_cnt_d;

  // Terminal-count decode and wrap-around of the prescaler.
  always_comb begin
    tick       = (tick_cnt_q == c_TICK_LAST);
    tick_cnt_d = tick ? '0 : (tick_cnt_q + c_ONE);
  end

  // Prescaler state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

endmodule : debounce_tick_gen
`default_nettype wire

// File: rtl/gpio_input_debounce.sv
`default_nettype none
// ============================================================================
// Module      : gpio_input_debounce
// Description : Two-flop synchroniser plus per-channel debounce for raw
//               push-button / switch inputs. A new level is accepted after
//               STABLE_TICKS consecutive mismatching sample ticks; each
//               accepted transition emits a one-cycle rise or fall strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_input_debounce
  import gpio_pkg::*;
#(
  parameter int               WIDTH        = GPIO_WIDTH,
  parameter int               TICK_DIV     = DEF_TICK_DIV,
  parameter int               STABLE_TICKS = DEF_STABLE_TICKS,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  // Counter must hold 0..STABLE_TICKS-1; the extra +1 keeps STABLE_TICKS = 1
  // at a legal one-bit width.
  localparam int             CW          = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0]  c_ACCEPT_AT = CW'(STABLE_TICKS - 1);
  localparam logic [CW-1:0]  c_CNT_ONE   = CW'(1);

  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;
  logic             tick;

  // Shared sample-tick prescaler for all channels.
  debounce_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Plain two-flop synchroniser; nothing may sit between the stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= RESET_VALUE;
      sync_q2 <= RESET_VALUE;
    end else begin
      sync_q1 <= raw_in;
      sync_q2 <= sync_q1;
    end
  end

  // Independent debounce state for every channel.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic          clean_q;
    logic          clean_d;
    logic          rise_q;
    logic          rise_d;
    logic          fall_q;
    logic          fall_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    ch_action_e    act;

    // Classify this edge, then derive next count, level and strobes.
    always_comb begin
      act     = CH_MATCH;
      cnt_d   = '0;
      clean_d = clean_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;

      if (sync_q2[i] == clean_q) begin
        act = CH_MATCH;
      end else if (!tick) begin
        act = CH_WAIT;
      end else if (cnt_q == c_ACCEPT_AT) begin
        act = CH_ACCEPT;
      end else begin
        act = CH_COUNT;
      end

      case (act)
        CH_MATCH: begin
          cnt_d = '0;
        end
        CH_WAIT: begin
          cnt_d = cnt_q;
        end
        CH_COUNT: begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
        CH_ACCEPT: begin
          cnt_d   = '0;
          clean_d = sync_q2[i];
          rise_d  = sync_q2[i];
          fall_d  = ~sync_q2[i];
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end

    // Channel state; reset forces the level without raising a strobe.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        clean_q <= RESET_VALUE[i];
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        clean_q <= clean_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        cnt_q   <= cnt_d;
      end
    end

    assign clean_out[i]  = clean_q;
    assign rise_pulse[i] = rise_q;
    assign fall_pulse[i] = fall_q;
  end : g_ch

endmodule : gpio_input_debounce
`default_nettype wire

// File: tb/tb_gpio_input_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_input_debounce
// Description : Directed self-checking bench for gpio_input_debounce
//               (WIDTH=4, TICK_DIV=4, STABLE_TICKS=3) plus a second instance
//               with TICK_DIV=1, STABLE_TICKS=1 for the fastest-path case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_input_debounce;

  logic       clk;
  logic       reset;
  logic [3:0] raw_in;
  logic [3:0] clean_out;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;

  logic [3:0] raw6;
  logic [3:0] clean6;
  logic [3:0] rise6;
  logic [3:0] fall6;

  int n_vec = 0;
  int n_bad = 0;

  int rise_cnt [4];
  int fall_cnt [4];
  int overlap_cnt = 0;

  gpio_input_debounce #(
    .WIDTH        (4),
    .TICK_DIV     (4),
    .STABLE_TICKS (3),
    .RESET_VALUE  (4'h0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_in     (raw_in),
    .clean_out  (clean_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  gpio_input_debounce #(
    .WIDTH        (4),
    .TICK_DIV     (1),
    .STABLE_TICKS (1),
    .RESET_VALUE  (4'h0)
  ) dut6 (
    .clk        (clk),
    .reset      (reset),
    .raw_in     (raw6),
    .clean_out  (clean6),
    .rise_pulse (rise6),
    .fall_pulse (fall6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe tally for the main instance, sampled away from the active edge.
  always @(negedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (rise_pulse[b]) rise_cnt[b] = rise_cnt[b] + 1;
      if (fall_pulse[b]) fall_cnt[b] = fall_cnt[b] + 1;
    end
    if ((rise_pulse & fall_pulse) != 4'h0) overlap_cnt = overlap_cnt + 1;
    if ((rise6 & fall6) != 4'h0) overlap_cnt = overlap_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_tally();
    for (int b = 0; b < 4; b++) begin
      rise_cnt[b] = 0;
      fall_cnt[b] = 0;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until clean_out reaches tgt or the cycle budget runs out.
  task automatic wait_clean(input logic [3:0] tgt, input int maxc, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while ((clean_out !== tgt) && (n < maxc));
  endtask

  task automatic settle(input logic [3:0] tgt);
    int n;
    raw_in = tgt;
    wait_clean(tgt, 20, n);
    chk("settle", {28'h0, clean_out}, {28'h0, tgt});
    step(2);
  endtask

  int         n;
  int         bad;
  logic [3:0] prev;
  logic [3:0] vec6 [7] = '{4'h1, 4'h3, 4'hA, 4'h5, 4'h0, 4'hF, 4'h0};

  initial begin
    reset  = 1'b1;
    raw_in = 4'hF;
    raw6   = 4'h0;
    clr_tally();

    // 1. Reset holds outputs low regardless of the raw pins.
    step(5);
    chk("t1_rst_clean", {28'h0, clean_out}, 32'h0);
    chk("t1_rst_rise", {28'h0, rise_pulse}, 32'h0);
    chk("t1_rst_fall", {28'h0, fall_pulse}, 32'h0);
    reset = 1'b0;
    wait_clean(4'hF, 20, n);
    chk("t1_lat_11_14", {31'h0, (n >= 11 && n <= 14)}, 32'h1);
    chk("t1_clean", {28'h0, clean_out}, 32'hF);
    chk("t1_rise", {28'h0, rise_pulse}, 32'hF);
    chk("t1_fall", {28'h0, fall_pulse}, 32'h0);
    step(1);
    chk("t1_rise_1cyc", {28'h0, rise_pulse}, 32'h0);

    // 2. Bouncing bit 0 never qualifies; final stable edge does, once.
    settle(4'hE);
    clr_tally();
    bad = 0;
    for (int k = 0; k < 14; k++) begin
      raw_in[0] = (k % 2 == 0);
      repeat (3) begin
        step(1);
        if (clean_out !== 4'hE) bad++;
      end
    end
    chk("t2_bounce_hold", bad, 0);
    chk("t2_bounce_norise", rise_cnt[0], 0);
    raw_in[0] = 1'b1;
    wait_clean(4'hF, 20, n);
    chk("t2_lat_11_14", {31'h0, (n >= 11 && n <= 14)}, 32'h1);
    step(3);
    chk("t2_single_rise", rise_cnt[0], 1);

    // 3. An 8-cycle low glitch on bit 1 is rejected and leaves no count behind.
    clr_tally();
    raw_in[1] = 1'b0;
    step(8);
    raw_in[1] = 1'b1;
    bad = 0;
    repeat (20) begin
      step(1);
      if (clean_out[1] !== 1'b1) bad++;
    end
    chk("t3_glitch_hold", bad, 0);
    chk("t3_no_fall", fall_cnt[1], 0);
    raw_in[1] = 1'b0;
    wait_clean(4'hD, 20, n);
    chk("t3_full_requal", {31'h0, (n >= 11 && n <= 14)}, 32'h1);
    chk("t3_fall", {28'h0, fall_pulse}, 32'h2);

    // 4. Simultaneous opposite transitions on all bits.
    settle(4'b0011);
    raw_in = 4'b1100;
    wait_clean(4'b1100, 20, n);
    chk("t4_clean", {28'h0, clean_out}, 32'hC);
    chk("t4_rise", {28'h0, rise_pulse}, 32'hC);
    chk("t4_fall", {28'h0, fall_pulse}, 32'h3);

    // 5. Reset mid-qualification clears at once and restarts the timer.
    settle(4'b1000);
    clr_tally();
    raw_in = 4'b1100;
    step(6);
    reset = 1'b1;
    #1;
    chk("t5_rst_clean", {28'h0, clean_out}, 32'h0);
    chk("t5_rst_pulses", {24'h0, rise_pulse, fall_pulse}, 32'h0);
    step(3);
    chk("t5_rst_no_fall", fall_cnt[3], 0);
    reset = 1'b0;
    wait_clean(4'b1100, 20, n);
    chk("t5_lat_11_14", {31'h0, (n >= 11 && n <= 14)}, 32'h1);
    chk("t5_rise", {28'h0, rise_pulse}, 32'hC);

    // 6. TICK_DIV=1, STABLE_TICKS=1: exact 3-cycle latency, one strobe each.
    prev = clean6;
    chk("t6_start", {28'h0, prev}, 32'h0);
    for (int v = 0; v < 7; v++) begin
      raw6 = vec6[v];
      step(2);
      chk("t6_still_old", {28'h0, clean6}, {28'h0, prev});
      step(1);
      chk("t6_clean", {28'h0, clean6}, {28'h0, vec6[v]});
      chk("t6_rise", {28'h0, rise6}, {28'h0, vec6[v] & ~prev});
      chk("t6_fall", {28'h0, fall6}, {28'h0, prev & ~vec6[v]});
      step(1);
      chk("t6_strobe_1cyc", {24'h0, rise6, fall6}, 32'h0);
      prev = vec6[v];
    end

    chk("no_rise_fall_overlap", overlap_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_gpio_input_debounce
`default_nettype wire
